// File: rtl/coordinates_scan_if.sv
// -----------------------------------------------------------------------------
// coordinates_scan_if
//
// Bundles the control handshake, the image-memory read port and the result
// bus of the coordinates stage.
//
//   slave  : the scan block (coordinates_scan)
//   master : the control unit / image memory / detection side
//
// Signals:
//   in_enable        level request from the control unit
//   out_mem_read     read strobe to the image memory
//   out_mem_address  pixel address, y*IMG_WIDTH + x
//   in_mem_readdata  pixel data, valid one cycle after the read strobe
//   out_done         results valid; held until in_enable falls
//   out_found        at least one foreground pixel seen
//   out_x_min/max    horizontal bounding box
//   out_y_min/max    vertical bounding box
//   out_count        number of foreground pixels
//   out_sum_x/y      coordinate sums (only with COORDINATES_SUM_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface coordinates_scan_if #(
   parameter int ADDR_W = 19,
   parameter int X_W    = 10,
   parameter int Y_W    = 9,
   parameter int CNT_W  = 19,
   parameter int SUM_W  = 28
) ();

   logic              in_enable;
   logic              out_mem_read;
   logic [ADDR_W-1:0] out_mem_address;
   logic [7:0]        in_mem_readdata;
   logic              out_done;
   logic              out_found;
   logic [X_W-1:0]    out_x_min;
   logic [X_W-1:0]    out_x_max;
   logic [Y_W-1:0]    out_y_min;
   logic [Y_W-1:0]    out_y_max;
   logic [CNT_W-1:0]  out_count;
`ifdef COORDINATES_SUM_EN
   logic [SUM_W-1:0]  out_sum_x;
   logic [SUM_W-1:0]  out_sum_y;

   modport slave (
      input  in_enable, in_mem_readdata,
      output out_mem_read, out_mem_address, out_done, out_found,
             out_x_min, out_x_max, out_y_min, out_y_max, out_count,
             out_sum_x, out_sum_y
   );

   modport master (
      output in_enable, in_mem_readdata,
      input  out_mem_read, out_mem_address, out_done, out_found,
             out_x_min, out_x_max, out_y_min, out_y_max, out_count,
             out_sum_x, out_sum_y
   );
`else
   modport slave (
      input  in_enable, in_mem_readdata,
      output out_mem_read, out_mem_address, out_done, out_found,
             out_x_min, out_x_max, out_y_min, out_y_max, out_count
   );

   modport master (
      output in_enable, in_mem_readdata,
      input  out_mem_read, out_mem_address, out_done, out_found,
             out_x_min, out_x_max, out_y_min, out_y_max, out_count
   );
`endif

endinterface

// File: rtl/coordinates_scan.sv
// -----------------------------------------------------------------------------
// coordinates_scan
//
// Raster-scans a stored greyscale image and reduces every pixel whose value
// is >= THRESHOLD to a bounding box, a pixel count and (optionally) the sums
// of the x and y coordinates. Started by the control unit via in_enable,
// completion signalled on out_done.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous, active-high
//   bus    coordinates_scan_if.slave (handshake, memory port, results)
//
// Optional feature macro: COORDINATES_SUM_EN
//   defined   -> out_sum_x / out_sum_y accumulators and ports exist
//   undefined -> sums absent; all other behaviour identical
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module coordinates_scan #(
   parameter int         IMG_WIDTH  = 640,
   parameter int         IMG_HEIGHT = 480,
   parameter int         ADDR_W     = 19,
   parameter int         X_W        = 10,
   parameter int         Y_W        = 9,
   parameter int         CNT_W      = 19,
   parameter int         SUM_W      = 28,
   parameter logic [7:0] THRESHOLD  = 8'd128
) (
   input logic            clock,
   input logic            reset,
   coordinates_scan_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_WIDTH - 1);

   logic [1:0]        state;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_address;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;

   // Issued coordinate delayed one cycle so it lines up with the read data.
   logic              pipe_valid;
   logic [X_W-1:0]    pipe_x;
   logic [Y_W-1:0]    pipe_y;

   logic              done;
   logic              found;
   logic [X_W-1:0]    x_min;
   logic [X_W-1:0]    x_max;
   logic [Y_W-1:0]    y_min;
   logic [Y_W-1:0]    y_max;
   logic [CNT_W-1:0]  count;
`ifdef COORDINATES_SUM_EN
   logic [SUM_W-1:0]  sum_x;
   logic [SUM_W-1:0]  sum_y;
`endif

   logic start;
   logic foreground;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path through the block leaves it unassigned and a latch is inferred.
   always_comb begin
      start      = 1'b0;
      foreground = 1'b0;
      if (state == S_IDLE && bus.in_enable)
         start = 1'b1;
      // Only pixels returning while the scan is live are accumulated; a
      // stale pipeline entry left by an abort lands in IDLE and is ignored.
      if (pipe_valid && (state == S_SCAN || state == S_DRAIN) &&
          bus.in_mem_readdata >= THRESHOLD)
         foreground = 1'b1;
   end

   // Control FSM and address generation. The address is a running counter
   // kept in step with (x,y), so no multiplier is needed.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         mem_read    <= 1'b0;
         mem_address <= '0;
         x           <= '0;
         y           <= '0;
         done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_enable) begin
                  state       <= S_SCAN;
                  mem_read    <= 1'b1;
                  mem_address <= '0;
                  x           <= '0;
                  y           <= '0;
               end
            end
            S_SCAN: begin
               if (!bus.in_enable) begin
                  state       <= S_IDLE;
                  mem_read    <= 1'b0;
                  mem_address <= '0;
                  x           <= '0;
                  y           <= '0;
               end else if (mem_address == LAST_ADDR) begin
                  state    <= S_DRAIN;
                  mem_read <= 1'b0;
               end else begin
                  mem_address <= mem_address + ADDR_W'(1);
                  if (x == LAST_X) begin
                     x <= '0;
                     y <= y + Y_W'(1);
                  end else begin
                     x <= x + X_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // Last pixel is accumulated on this same edge.
               if (!bus.in_enable) begin
                  state <= S_IDLE;
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               // Holding in_enable high keeps the block here; no restart.
               if (!bus.in_enable) begin
                  state <= S_IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               mem_read <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pipe_valid <= 1'b0;
         pipe_x     <= '0;
         pipe_y     <= '0;
      end else begin
         pipe_valid <= mem_read;
         pipe_x     <= x;
         pipe_y     <= y;
      end
   end

   // Result accumulators. A start clears everything, which also discards
   // any partial results left behind by an aborted scan and leaves an empty
   // frame with an all-zero box.
   always_ff @(posedge clock) begin
      if (reset || start) begin
         found <= 1'b0;
         x_min <= '0;
         x_max <= '0;
         y_min <= '0;
         y_max <= '0;
         count <= '0;
`ifdef COORDINATES_SUM_EN
         sum_x <= '0;
         sum_y <= '0;
`endif
      end else if (foreground) begin
         count <= count + CNT_W'(1);
         found <= 1'b1;
`ifdef COORDINATES_SUM_EN
         sum_x <= sum_x + SUM_W'(pipe_x);
         sum_y <= sum_y + SUM_W'(pipe_y);
`endif
         if (!found) begin
            x_min <= pipe_x;
            x_max <= pipe_x;
            y_min <= pipe_y;
            y_max <= pipe_y;
         end else begin
            if (pipe_x < x_min) x_min <= pipe_x;
            if (pipe_x > x_max) x_max <= pipe_x;
            if (pipe_y < y_min) y_min <= pipe_y;
            if (pipe_y > y_max) y_max <= pipe_y;
         end
      end
   end

   assign bus.out_mem_read    = mem_read;
   assign bus.out_mem_address = mem_address;
   assign bus.out_done        = done;
   assign bus.out_found       = found;
   assign bus.out_x_min       = x_min;
   assign bus.out_x_max       = x_max;
   assign bus.out_y_min       = y_min;
   assign bus.out_y_max       = y_max;
   assign bus.out_count       = count;
`ifdef COORDINATES_SUM_EN
   assign bus.out_sum_x       = sum_x;
   assign bus.out_sum_y       = sum_y;
`endif

endmodule

// File: tb/tb_coordinates_scan.sv
// -----------------------------------------------------------------------------
// tb_coordinates_scan
//
// Scoreboard bench for coordinates_scan on an 8x4 image. Each started frame
// pushes its hand-computed result into a queue; a monitor pops and compares
// when out_done rises. Timing, handshake, abort and reset behaviour are
// checked directly by the stimulus thread.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_coordinates_scan;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int AW = 5;
   localparam int XW = 3;
   localparam int YW = 2;
   localparam int CW = 6;
   localparam int SW = 8;

   typedef struct {
      logic          found;
      logic [XW-1:0] x_min;
      logic [XW-1:0] x_max;
      logic [YW-1:0] y_min;
      logic [YW-1:0] y_max;
      logic [CW-1:0] count;
      logic [SW-1:0] sum_x;
      logic [SW-1:0] sum_y;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   coordinates_scan_if #(.ADDR_W(AW), .X_W(XW), .Y_W(YW), .CNT_W(CW), .SUM_W(SW)) bus ();

   coordinates_scan #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .X_W(XW), .Y_W(YW),
      .CNT_W(CW), .SUM_W(SW), .THRESHOLD(8'd128)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   // One-cycle image memory.
   logic [7:0] img [0:N-1];
   always @(posedge clock) begin
      if (reset)
         bus.in_mem_readdata <= 8'd0;
      else if (bus.out_mem_read)
         bus.in_mem_readdata <= img[bus.out_mem_address];
   end

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_reads  = 0;
   logic prev_done = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic f, input int xmn, input int xmx, input int ymn,
                               input int ymx, input int cnt, input int sx, input int sy);
      exp_t e;
      e.found = f;
      e.x_min = XW'(xmn);
      e.x_max = XW'(xmx);
      e.y_min = YW'(ymn);
      e.y_max = YW'(ymx);
      e.count = CW'(cnt);
      e.sum_x = SW'(sx);
      e.sum_y = SW'(sy);
      return e;
   endfunction

   // Monitor: counts read strobes and scores every rising out_done.
   always @(negedge clock) begin
      if (bus.out_mem_read) n_reads++;
      if (bus.out_done && !prev_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("found", 32'(bus.out_found), 32'(mon_e.found));
            check("x_min", 32'(bus.out_x_min), 32'(mon_e.x_min));
            check("x_max", 32'(bus.out_x_max), 32'(mon_e.x_max));
            check("y_min", 32'(bus.out_y_min), 32'(mon_e.y_min));
            check("y_max", 32'(bus.out_y_max), 32'(mon_e.y_max));
            check("count", 32'(bus.out_count), 32'(mon_e.count));
`ifdef COORDINATES_SUM_EN
            check("sum_x", 32'(bus.out_sum_x), 32'(mon_e.sum_x));
            check("sum_y", 32'(bus.out_sum_y), 32'(mon_e.sum_y));
`endif
         end
      end
      prev_done = bus.out_done;
   end

   // kind: 0 empty, 1 full, 2 single pixel (5,2), 3 rectangle
   task automatic fill(input int kind);
      for (int yy = 0; yy < H; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            case (kind)
               1:       img[yy*W+xx] = 8'd255;
               2:       img[yy*W+xx] = (xx == 5 && yy == 2) ? 8'd200 : 8'd10;
               3: begin
                  if (xx >= 2 && xx <= 4 && yy >= 1)
                     img[yy*W+xx] = (xx == 2 && yy == 1) ? 8'd128 : 8'd200;
                  else if (xx == 6 && yy == 0)
                     img[yy*W+xx] = 8'd127;
                  else
                     img[yy*W+xx] = 8'd0;
               end
               default: img[yy*W+xx] = 8'd0;
            endcase
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_read"},  32'(bus.out_mem_read),    32'd0);
      check({tag, "_addr"},  32'(bus.out_mem_address), 32'd0);
      check({tag, "_done"},  32'(bus.out_done),        32'd0);
      check({tag, "_found"}, 32'(bus.out_found),       32'd0);
      check({tag, "_box"},   32'({bus.out_x_min, bus.out_x_max, bus.out_y_min, bus.out_y_max}), 32'd0);
      check({tag, "_count"}, 32'(bus.out_count),       32'd0);
`ifdef COORDINATES_SUM_EN
      check({tag, "_sums"},  32'({bus.out_sum_x, bus.out_sum_y}), 32'd0);
`endif
   endtask

   // Start a frame, wait (bounded) for out_done, check latency and reads.
   task automatic run_frame(input string tag, input exp_t e);
      int cyc;
      exp_q.push_back(e);
      @(negedge clock);
      n_reads = 0;
      bus.in_enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!bus.out_done && cyc < 100);
      check({tag, "_latency"}, 32'(cyc), 32'(N + 2));
      check({tag, "_reads"}, 32'(n_reads), 32'(N));
   endtask

   task automatic release_enable(input string tag);
      bus.in_enable = 1'b0;
      @(negedge clock);
      check({tag, "_done_fall"}, 32'(bus.out_done), 32'd0);
   endtask

   initial begin
      int hi;
      reset = 1'b1;
      bus.in_enable = 1'b0;
      fill(0);
      repeat (3) @(negedge clock);
      check_zero("reset");
      reset = 1'b0;

      // Single pixel, then hold enable past done.
      fill(2);
      run_frame("single", mk(1'b1, 5, 5, 2, 2, 1, 5, 2));
      n_reads = 0;
      hi = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.out_done) hi++;
      end
      check("hold_done", 32'(hi), 32'd20);
      check("hold_reads", 32'(n_reads), 32'd0);
      release_enable("single");

      fill(3);
      run_frame("rect", mk(1'b1, 2, 4, 1, 3, 9, 27, 18));
      release_enable("rect");

      fill(0);
      run_frame("empty", mk(1'b0, 0, 0, 0, 0, 0, 0, 0));
      release_enable("empty");

      fill(1);
      run_frame("full", mk(1'b1, 0, 7, 0, 3, 32, 112, 48));
      release_enable("full");

      // Abort at scan cycle 10, then restart on the rectangle.
      @(negedge clock);
      bus.in_enable = 1'b1;
      repeat (10) @(negedge clock);
      bus.in_enable = 1'b0;
      @(negedge clock);
      check("abort_read", 32'(bus.out_mem_read), 32'd0);
      hi = 0;
      repeat (4) begin
         if (bus.out_done) hi++;
         @(negedge clock);
      end
      check("abort_no_done", 32'(hi), 32'd0);
      fill(3);
      run_frame("restart", mk(1'b1, 2, 4, 1, 3, 9, 27, 18));
      release_enable("restart");

      // Reset for one cycle mid-scan, then a clean frame.
      fill(1);
      @(negedge clock);
      bus.in_enable = 1'b1;
      repeat (8) @(negedge clock);
      reset = 1'b1;
      bus.in_enable = 1'b0;
      @(negedge clock);
      check_zero("midreset");
      reset = 1'b0;
      @(negedge clock);
      fill(2);
      run_frame("after_reset", mk(1'b1, 5, 5, 2, 2, 1, 5, 2));
      release_enable("after_reset");

      repeat (2) @(negedge clock);
      check("pending_results", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
